// File: rtl/sign_ext_pkg.sv
// Shared width constants and the reference sign-extension function used by
// both the datapath and its verification model.
package sign_ext_pkg;

    localparam int IMM13_W = 13;
    localparam int WORD_W  = 32;

    // Replicate bit in_w-1 of value into every bit at or above in_w.
    function automatic logic [WORD_W-1:0] sext(input logic [WORD_W-1:0] value,
                                               input int                in_w);
        logic [WORD_W-1:0] r_res;
        r_res = value;
        for (int i = 0; i < WORD_W; i++) begin
            if (i >= in_w) r_res[i] = value[in_w-1];
        end
        return r_res;
    endfunction

endpackage

// File: rtl/sign_ext_core.sv
// Combinational sign replication of an IN_W-bit two's-complement field
// into an OUT_W-bit word.
module sign_ext_core
    import sign_ext_pkg::*;
#(
    parameter int IN_W  = IMM13_W,
    parameter int OUT_W = WORD_W
) (
    input  logic [IN_W-1:0]  i_val,
    output logic [OUT_W-1:0] o_val
);

    // A zero-width replication is illegal, so equal widths pass straight through.
    generate
        if (IN_W == OUT_W) begin : g_pass
            assign o_val = i_val;
        end else begin : g_ext
            assign o_val = {{(OUT_W-IN_W){i_val[IN_W-1]}}, i_val};
        end
    endgenerate

endmodule

// File: rtl/sign_extend_13_32.sv
// Sign extender top: wraps sign_ext_core; defining SIGN_EXTEND_REG_EN adds a
// one-cycle output register with synchronous active-high reset.
module sign_extend_13_32
    import sign_ext_pkg::*;
#(
    parameter int IN_W  = IMM13_W,
    parameter int OUT_W = WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  Entrada,
    output logic [OUT_W-1:0] Salida,
    output logic             Negativo
);

    generate
        if (IN_W < 2 || IN_W > OUT_W) begin : g_bad_width
            $error("sign_extend_13_32: IN_W must lie in 2..OUT_W");
        end
    endgenerate

    logic [OUT_W-1:0] w_ext;

    sign_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .i_val (Entrada),
        .o_val (w_ext)
    );

`ifdef SIGN_EXTEND_REG_EN
    // Sign flag and word share one register so they always change together.
    logic [OUT_W:0] r_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out <= '0;
        end else begin
            r_out <= {w_ext[OUT_W-1], w_ext};
        end
    end

    assign Salida   = r_out[OUT_W-1:0];
    assign Negativo = r_out[OUT_W];
`else
    logic w_unused_ctrl;
    assign w_unused_ctrl = &{1'b0, clk, reset};

    assign Salida   = w_ext;
    assign Negativo = w_ext[OUT_W-1];
`endif

endmodule

// File: tb/tb_sign_extend_13_32.sv
// Directed and exhaustive bench for sign_extend_13_32; works in both the
// combinational build and the SIGN_EXTEND_REG_EN registered build.
module tb_sign_extend_13_32;
    import sign_ext_pkg::*;

    logic        clk;
    logic        reset;
    logic [12:0] Entrada;
    logic [31:0] Salida;
    logic        Negativo;

    int n_total;
    int n_bad;

    sign_extend_13_32 #(
        .IN_W  (13),
        .OUT_W (32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .Entrada  (Entrada),
        .Salida   (Salida),
        .Negativo (Negativo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Present a vector and wait until its response is due.
    task automatic drive(input logic [12:0] v);
        @(negedge clk);
        Entrada = v;
`ifdef SIGN_EXTEND_REG_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    task automatic vec(input string tag, input logic [12:0] v,
                       input logic [31:0] exp_s, input logic exp_n);
        drive(v);
        check(tag, Salida, exp_s);
        check({tag, "_neg"}, {31'b0, Negativo}, {31'b0, exp_n});
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset   = 1'b1;
        Entrada = 13'h1FFF;
        repeat (2) @(posedge clk);
        #1;
`ifdef SIGN_EXTEND_REG_EN
        check("reset_sal", Salida, 32'h0000_0000);
        check("reset_neg", {31'b0, Negativo}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset", Salida, 32'hFFFF_FFFF);
        check("post_reset_neg", {31'b0, Negativo}, 32'h1);
`else
        check("reset_ignored", Salida, 32'hFFFF_FFFF);
        check("reset_ignored_neg", {31'b0, Negativo}, 32'h1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_reset", Salida, 32'hFFFF_FFFF);
`endif

        vec("zero",     13'b0000000000000, 32'h0000_0000, 1'b0);
        vec("min_plus", 13'b1000000000001, 32'hFFFF_F001, 1'b1);
        vec("pos_ee3",  13'b0111011100011, 32'h0000_0EE3, 1'b0);
        vec("pos_fc0",  13'b0111111000000, 32'h0000_0FC0, 1'b0);
        vec("neg_555",  13'b1010101010101, 32'hFFFF_F555, 1'b1);
        vec("max_pos",  13'b0111111111111, 32'h0000_0FFF, 1'b0);
        vec("most_neg", 13'b1000000000000, 32'hFFFF_F000, 1'b1);

`ifdef SIGN_EXTEND_REG_EN
        // Output must hold until the next rising edge.
        @(negedge clk);
        Entrada = 13'b0000000000001;
        #1;
        check("latency_hold", Salida, 32'hFFFF_F000);
        @(posedge clk);
        #1;
        check("latency_load", Salida, 32'h0000_0001);

        // Reset wins over Entrada at the same edge.
        @(negedge clk);
        reset   = 1'b1;
        Entrada = 13'h1FFF;
        @(posedge clk);
        #1;
        check("reset_prio", Salida, 32'h0000_0000);
        @(negedge clk);
        reset = 1'b0;
`endif

        for (int i = 0; i < 8192; i++) begin
            logic [31:0] exp_w;
            exp_w = sext(32'(i), 13);
            drive(13'(i));
            check("sweep", Salida, exp_w);
            check("sweep_neg", {31'b0, Negativo}, {31'b0, exp_w[31]});
        end

        vec("all_ones", 13'b1111111111111, 32'hFFFF_FFFF, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("all_ones_hold", Salida, 32'hFFFF_FFFF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/sign_extend_13_32.md
SIGN_EXTEND_13_32 -- requirements
Module: sign_extend_13_32

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter IN_W, default 13: input field width in bits; legal range 2..OUT_W.
REQ-003 Parameter OUT_W, default 32: output word width in bits.
REQ-004 Port clk, input, 1 bit: rising-edge clock; used only when SIGN_EXTEND_REG_EN is defined.
REQ-005 Port reset, input, 1 bit: synchronous active-high reset; used only when SIGN_EXTEND_REG_EN is defined.
REQ-006 Port Entrada, input, IN_W bits: two's-complement immediate to be extended.
REQ-007 Port Salida, output, OUT_W bits: sign-extended result.
REQ-008 Port Negativo, output, 1 bit: copy of the sign bit carried by Salida (Salida[OUT_W-1]).

Function
REQ-009 Salida[IN_W-1:0] SHALL equal Entrada[IN_W-1:0] bit for bit.
REQ-010 Salida[OUT_W-1:IN_W] SHALL all equal Entrada[IN_W-1].
REQ-011 With the defaults, the signed value of Salida SHALL equal the signed value of Entrada for every input from -4096 to +4095.
REQ-012 When IN_W equals OUT_W, Salida SHALL equal Entrada unchanged.
REQ-013 Without SIGN_EXTEND_REG_EN the path SHALL be purely combinational, with zero latency.
REQ-014 Without SIGN_EXTEND_REG_EN, Salida and Negativo SHALL settle within the same delta cycle as any change on Entrada, including X and Z propagation.
REQ-015 With SIGN_EXTEND_REG_EN, Salida and Negativo SHALL update only on the rising edge of clk, with one-cycle latency from Entrada.
REQ-016 The block SHALL contain no other state, no handshake and no back-pressure.

Reset
REQ-017 With SIGN_EXTEND_REG_EN, reset high at a rising edge SHALL force Salida to all zeros and Negativo to 0.
REQ-018 Reset SHALL take priority over Entrada at the same edge.
REQ-019 On the first edge after reset deasserts, Salida SHALL load the extension of the Entrada value present at that edge.
REQ-020 Without SIGN_EXTEND_REG_EN, reset SHALL have no effect on the outputs.

Configuration
REQ-021 Macro SIGN_EXTEND_REG_EN SHALL select the output structure.
REQ-022 With SIGN_EXTEND_REG_EN defined, an OUT_W+1-bit output register SHALL be instantiated and REQ-015 and REQ-017..019 SHALL apply.
REQ-023 With SIGN_EXTEND_REG_EN undefined, no flops SHALL be inferred and clk and reset SHALL remain as unused ports.
REQ-024 The port list SHALL be identical in both builds.

Structure
REQ-025 A shared package sign_ext_pkg SHALL hold:
- default width constants IMM13_W = 13 and WORD_W = 32;
- a function sext(value, in_w) returning a WORD_W-bit extension, reused by the verification model.
REQ-026 One sub-module, sign_ext_core, SHALL hold the combinational replication logic.
REQ-027 The top level SHALL wrap sign_ext_core with the optional register.
REQ-028 The top level SHALL elaborate an error if IN_W < 2 or IN_W > OUT_W.

Verification
REQ-029 The bench SHALL run every scenario below in both builds; in the registered build, each response is checked one edge later.
REQ-030 Entrada = 13'b0000000000000 -> Salida = 32'h00000000, Negativo = 0.
REQ-031 Entrada = 13'b1000000000001 -> Salida = 32'hFFFFF001, Negativo = 1.
REQ-032 Entrada = 13'b0111011100011 -> Salida = 32'h00000EE3, and Entrada = 13'b0111111000000 -> Salida = 32'h00000FC0.
REQ-033 Entrada = 13'b1010101010101 -> Salida = 32'hFFFFF555, and Entrada = 13'b1111111111111 -> Salida = 32'hFFFFFFFF held until end of test.
REQ-034 Registered build, reset high with Entrada = 13'h1FFF -> Salida = 0; reset low -> Salida = 32'hFFFFFFFF after one edge.
REQ-035 The bench SHALL run an exhaustive sweep of all 8192 Entrada values and compare Salida against sext() from sign_ext_pkg with zero mismatches.
